// File: rtl/decoder3to8_seq.sv
// Registered 3-to-8 one-hot strobe driver with valid/ready intake, HOLD-cycle strobe
// and a break-before-make zero cycle between consecutive codes.
module decoder3to8_seq #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned CW   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [7:0] y,
  output logic [2:0] active_code,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GAP
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [7:0]      y_n;
  logic [2:0]      active_n;
  logic            busy_n;
  logic            done_n;

  // rst gates ready so nothing looks acceptable while the block is held in reset
  assign code_ready = (state == S_IDLE) & en & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      y           <= '0;
      active_code <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      y           <= y_n;
      active_code <= active_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    y_n      = y;
    active_n = active_code;
    busy_n   = busy;
    done_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (code_valid && code_ready) begin
          state_n  = S_HOLD;
          y_n      = 8'b1 << code_in;
          active_n = code_in;
          cnt_n    = CW'(HOLD - 1);
          busy_n   = 1'b1;
        end
      end
      S_HOLD: begin
        // abort takes priority over normal completion; it skips GAP and never pulses done
        if (!en) begin
          state_n  = S_IDLE;
          y_n      = '0;
          active_n = '0;
          busy_n   = 1'b0;
          cnt_n    = '0;
        end else if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          state_n = S_GAP;
          y_n     = '0;
          done_n  = 1'b1;
        end
      end
      S_GAP: begin
        state_n  = S_IDLE;
        busy_n   = 1'b0;
        active_n = '0;
      end
      default: begin
        state_n  = S_IDLE;
        y_n      = '0;
        active_n = '0;
        busy_n   = 1'b0;
        cnt_n    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_decoder3to8_seq.sv
// Directed bench for decoder3to8_seq: a HOLD=4 instance for most scenarios and a
// HOLD=1 instance for the single-cycle strobe case; per-cycle invariant monitors.
module tb_decoder3to8_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, code_valid, code_ready, busy, done;
  logic [2:0] code_in, active_code;
  logic [7:0] y;
  logic       en1, code_valid1, code_ready1, busy1, done1;
  logic [2:0] code_in1, active_code1;
  logic [7:0] y1;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cnt1 = 0;
  int last_acc;
  int d0;

  logic [7:0] prev_y  = '0;
  logic [7:0] prev_y1 = '0;
  logic       acc_ok  = 1'b0;
  logic       acc_ok1 = 1'b0;

  logic [7:0] exp_y [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  decoder3to8_seq #(.HOLD(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .y(y), .active_code(active_code), .busy(busy), .done(done)
  );

  decoder3to8_seq #(.HOLD(1), .CW(8)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .code_in(code_in1), .code_valid(code_valid1),
    .code_ready(code_ready1), .y(y1), .active_code(active_code1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    check("onehot0", 32'($onehot0(y)), 1);
    if (y != 0 && prev_y == 0) check("accept_gated", 32'(acc_ok), 1);
    if (y != 0 && prev_y != 0) check("no_switch", y, prev_y);
    acc_ok = code_valid & code_ready;
    prev_y = y;
    if (done) done_cnt++;
  end

  always @(negedge clk) begin
    check("onehot0_h1", 32'($onehot0(y1)), 1);
    if (y1 != 0 && prev_y1 == 0) check("accept_gated_h1", 32'(acc_ok1), 1);
    if (y1 != 0 && prev_y1 != 0) check("no_switch_h1", y1, prev_y1);
    acc_ok1 = code_valid1 & code_ready1;
    prev_y1 = y1;
    if (done1) done_cnt1++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; code_in = '0; code_valid = 1'b0;
    en1 = 1'b0; code_in1 = '0; code_valid1 = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      en = 1'($urandom); code_in = 3'($urandom); code_valid = 1'($urandom);
      tick();
    end
    en = 1'b1; code_valid = 1'b1; #1;
    check("rst_y", y, 8'h00);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", code_ready, 0);
    check("rst_active", active_code, 0);
    rst = 1'b0; code_valid = 1'b0; #1;
    check("ready_after_rst", code_ready, 1);
    tick();
    check("idle_y", y, 8'h00);

    // full sweep, valid held high
    code_valid = 1'b1; code_in = 3'd0; last_acc = 0;
    for (int c = 0; c < 8; c++) begin
      check("sweep_ready_pre", code_ready, 1);
      tick();
      if (c > 0) check("sweep_spacing", cyc - last_acc, 6);
      last_acc = cyc;
      check("sweep_active", active_code, c);
      code_in = 3'(c + 1);
      if (c == 7) code_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        check("sweep_y", y, exp_y[c]);
        check("sweep_busy", busy, 1);
        check("sweep_ready_busy", code_ready, 0);
        if (k < 3) tick();
      end
      tick();
      check("sweep_gap_y", y, 8'h00);
      check("sweep_gap_done", done, 1);
      tick();
      check("sweep_idle_y", y, 8'h00);
      check("sweep_idle_done", done, 0);
      check("sweep_idle_busy", busy, 0);
    end
    check("sweep_done_count", done_cnt, 8);

    // abort mid-strobe
    d0 = done_cnt;
    code_in = 3'd5; code_valid = 1'b1;
    tick();
    check("abort_y1", y, 8'h20);
    code_valid = 1'b0;
    tick();
    check("abort_y2", y, 8'h20);
    en = 1'b0;
    tick();
    check("abort_y0", y, 8'h00);
    check("abort_busy", busy, 0);
    check("abort_active", active_code, 0);
    check("abort_done", done, 0);
    check("abort_ready_en0", code_ready, 0);
    en = 1'b1; #1;
    check("abort_ready_en1", code_ready, 1);
    tick();
    check("abort_after_y", y, 8'h00);
    check("abort_no_done", done_cnt, d0);

    // code_in sampled only at accept
    code_in = 3'd3; code_valid = 1'b1;
    tick();
    code_in = 3'd6; code_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("stable_y", y, 8'h08);
      check("stable_active", active_code, 3);
      if (k < 3) tick();
    end
    tick();
    check("stable_gap_y", y, 8'h00);
    check("stable_gap_done", done, 1);
    tick();
    check("stable_ready", code_ready, 1);

    // asynchronous reset mid-strobe
    d0 = done_cnt;
    code_in = 3'd4; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    check("arst_y_pre", y, 8'h10);
    tick();
    #1 rst = 1'b1;
    #1;
    check("arst_y", y, 8'h00);
    check("arst_busy", busy, 0);
    check("arst_active", active_code, 0);
    check("arst_done", done, 0);
    check("arst_ready", code_ready, 0);
    #2 rst = 1'b0;
    tick();
    check("arst_after_y", y, 8'h00);
    check("arst_after_ready", code_ready, 1);
    check("arst_no_done", done_cnt, d0);

    // HOLD=1 instance, stream 7 then 0
    en1 = 1'b1; code_in1 = 3'd7; code_valid1 = 1'b1; #1;
    check("h1_ready", code_ready1, 1);
    tick();
    check("h1_y7", y1, 8'h80);
    check("h1_busy", busy1, 1);
    code_in1 = 3'd0;
    tick();
    check("h1_gap_y", y1, 8'h00);
    check("h1_gap_done", done1, 1);
    tick();
    check("h1_idle_y", y1, 8'h00);
    check("h1_idle_done", done1, 0);
    check("h1_idle_ready", code_ready1, 1);
    tick();
    check("h1_y0", y1, 8'h01);
    check("h1_active0", active_code1, 0);
    code_valid1 = 1'b0;
    tick();
    check("h1_gap2_y", y1, 8'h00);
    check("h1_gap2_done", done1, 1);
    tick();
    check("h1_end_busy", busy1, 0);
    check("h1_done_count", done_cnt1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
